// File: rtl/l2_writeback_buffer_pkg.sv
// Shared LC-3b memory-side types plus the write-back buffer state encoding.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;
    typedef logic [11:0]  lc3b_line_addr;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FWD_READ = 2'd1,
        S_DRAIN    = 2'd2,
        S_RESP     = 2'd3
    } l2wb_state_t;

endpackage

// File: rtl/l2_wb_entry.sv
// Single buffered line: valid/address/data storage and the line-address hit compare.
module l2_wb_entry #(
    parameter int LINE_OFFSET_BITS = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_load,
    input  logic                        i_clear,
    input  logic [15-LINE_OFFSET_BITS:0] i_addr,
    input  logic [127:0]                i_data,
    input  logic [15-LINE_OFFSET_BITS:0] i_req_addr,
    output logic                        o_valid,
    output logic [15-LINE_OFFSET_BITS:0] o_addr,
    output logic [127:0]                o_data,
    output logic                        o_match
);

    logic                         r_valid;
    logic [15-LINE_OFFSET_BITS:0] r_addr;
    logic [127:0]                 r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_addr  <= i_addr;
            r_data  <= i_data;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_addr  = r_addr;
    assign o_data  = r_data;
    assign o_match = r_valid && (i_req_addr == r_addr);

endmodule

// File: rtl/l2_writeback_buffer.sv
// Single-entry write-back buffer between the L2 pmem port and physical memory;
// forwards read hits from the buffered line and lets read misses bypass the pending drain.
module l2_writeback_buffer
    import lc3b_types::*;
#(
    parameter int LINE_OFFSET_BITS = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [15:0]  mem_address,
    input  logic [127:0] mem_wdata,
    output logic         mem_resp,
    output logic [127:0] mem_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic         pmem_resp,
    input  logic [127:0] pmem_rdata,
    output logic         buf_empty
);

    localparam int LA_W = 16 - LINE_OFFSET_BITS;

    l2wb_state_t     r_state, w_state_next;
    lc3b_line        r_rdata;
    lc3b_line        w_rdata_next;
    logic            w_rdata_ld;
    logic            w_load, w_clear;
    logic            w_valid, w_match;
    logic [LA_W-1:0] w_req_line, w_buf_addr;
    lc3b_line        w_buf_data;
    logic            w_unused_ok;

    assign w_req_line  = mem_address[15:LINE_OFFSET_BITS];
    assign w_unused_ok = &{1'b0, mem_address[LINE_OFFSET_BITS-1:0]};

    l2_wb_entry #(.LINE_OFFSET_BITS(LINE_OFFSET_BITS)) u_entry (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_clear    (w_clear),
        .i_addr     (w_req_line),
        .i_data     (mem_wdata),
        .i_req_addr (w_req_line),
        .o_valid    (w_valid),
        .o_addr     (w_buf_addr),
        .o_data     (w_buf_data),
        .o_match    (w_match)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_rdata_ld)
                r_rdata <= w_rdata_next;
        end
    end

    // Read outranks write so an illegal read+write pair resolves as a read;
    // a write against a full buffer drains first and is re-sampled back in IDLE.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_clear      = 1'b0;
        w_rdata_ld   = 1'b0;
        w_rdata_next = w_buf_data;
        case (r_state)
            S_IDLE: begin
                if (mem_read) begin
                    if (w_match) begin
                        w_rdata_ld   = 1'b1;
                        w_state_next = S_RESP;
                    end else begin
                        w_state_next = S_FWD_READ;
                    end
                end else if (mem_write) begin
                    if (!w_valid) begin
                        w_load       = 1'b1;
                        w_state_next = S_RESP;
                    end else begin
                        w_state_next = S_DRAIN;
                    end
                end else if (w_valid) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_FWD_READ: begin
                if (pmem_resp) begin
                    w_rdata_ld   = 1'b1;
                    w_rdata_next = pmem_rdata;
                    w_state_next = S_RESP;
                end
            end
            S_DRAIN: begin
                if (pmem_resp) begin
                    w_clear      = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        if (r_state == S_FWD_READ) begin
            pmem_read    = 1'b1;
            pmem_address = {w_req_line, {LINE_OFFSET_BITS{1'b0}}};
        end else if (r_state == S_DRAIN) begin
            pmem_write   = 1'b1;
            pmem_address = {w_buf_addr, {LINE_OFFSET_BITS{1'b0}}};
            pmem_wdata   = w_buf_data;
        end
    end

    assign mem_resp  = (r_state == S_RESP);
    assign mem_rdata = r_rdata;
    assign buf_empty = !w_valid;

endmodule
